buzzer_alerta_farol: RTL and testbench

Sequential alarm driver that consumes the headlight-warning flag produced by the combinational headlight/door/key logic. It debounces the flag and drives an intermittent buzzer for a bounded number of beeps. After those beeps it falls back to a steady indicator LED until the warning clears. The block sits between the warning logic and the dashboard actuators: one input flag in, buzzer and LED drive out.

---
 rtl/buzzer_farol_pkg.sv | 19 +
 rtl/temporizador_farol.sv | 27 ++
 rtl/buzzer_alerta_farol.sv | 133 +++++++++++++
 tb/tb_buzzer_alerta_farol.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/buzzer_farol_pkg.sv
// Shared definitions for the headlight-warning buzzer driver: state
// encoding and the default timing constants.
package buzzer_farol_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    MUTE     = 3'd4
  } estado_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int T_ON_DEF       = 8;
  localparam int T_OFF_DEF      = 8;
  localparam int MAX_BEEPS_DEF  = 5;
  localparam int CNT_W_DEF      = 8;

endpackage

// File: rtl/temporizador_farol.sv
// Generic up-counter with synchronous clear, count enable and a
// terminal-count flag compared against a runtime limit.
module temporizador_farol #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limite,
  output logic             fim
);

  logic [CNT_W-1:0] cnt;

  // Counter register: clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign fim = (cnt == limite);

endmodule

// File: rtl/buzzer_alerta_farol.sv
// Headlight-warning alarm: debounces the warning flag, sounds a bounded
// number of beeps, then holds a steady LED until the warning clears.
module buzzer_alerta_farol
  import buzzer_farol_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int T_ON       = T_ON_DEF,
  parameter int T_OFF      = T_OFF_DEF,
  parameter int MAX_BEEPS  = MAX_BEEPS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic alerta,
  input  logic silenciar,
  output logic buzzer,
  output logic led_alerta,
  output logic mudo
);

  localparam logic [CNT_W-1:0] LIM_DEB   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_ON    = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] LIM_OFF   = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] MAX_B     = CNT_W'(MAX_BEEPS);
  localparam bit               AUTO_MUDO = (MAX_BEEPS != 0);

  estado_t          estado, estado_nxt;
  logic [CNT_W-1:0] bips, bips_nxt;
  logic [CNT_W-1:0] limite;
  logic             cnt_clr, cnt_en, fim;

  temporizador_farol #(.CNT_W(CNT_W)) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limite (limite),
    .fim    (fim)
  );

  // Next-state, counter control and beep-count update.
  // Priority: alerta drop > mute request > timer expiry.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    estado_nxt = estado;
    bips_nxt   = bips;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (estado)
      DEBOUNCE: limite = LIM_DEB;
      BEEP_ON:  limite = LIM_ON;
      BEEP_OFF: limite = LIM_OFF;
      default:  limite = '0;
    endcase

    if (estado == IDLE) begin
      cnt_clr  = 1'b1;
      bips_nxt = '0;
      if (alerta) estado_nxt = DEBOUNCE;
    end else if (!alerta) begin
      estado_nxt = IDLE;
      cnt_clr    = 1'b1;
      bips_nxt   = '0;
    end else if (silenciar && (estado != MUTE)) begin
      estado_nxt = MUTE;
      cnt_clr    = 1'b1;
      bips_nxt   = '0;
    end else begin
      case (estado)
        DEBOUNCE: begin
          if (fim) begin
            estado_nxt = BEEP_ON;
            cnt_clr    = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        BEEP_ON: begin
          if (fim) begin
            estado_nxt = BEEP_OFF;
            cnt_clr    = 1'b1;
            // With auto-mute disabled the count is never needed, so it
            // stays put and cannot wrap.
            if (AUTO_MUDO) bips_nxt = bips + CNT_W'(1);
          end else begin
            cnt_en = 1'b1;
          end
        end
        BEEP_OFF: begin
          if (fim) begin
            cnt_clr = 1'b1;
            if (AUTO_MUDO && (bips == MAX_B)) begin
              estado_nxt = MUTE;
              bips_nxt   = '0;
            end else begin
              estado_nxt = BEEP_ON;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        MUTE:    cnt_clr = 1'b1;
        default: begin
          estado_nxt = IDLE;
          cnt_clr    = 1'b1;
          bips_nxt   = '0;
        end
      endcase
    end
  end

  // State, beep count and registered Moore output decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only a handful of control flops here, so all of them are reset;
    // the outputs drop to 0 the moment rst rises.
    if (rst) begin
      estado     <= IDLE;
      bips       <= '0;
      buzzer     <= 1'b0;
      led_alerta <= 1'b0;
      mudo       <= 1'b0;
    end else begin
      estado     <= estado_nxt;
      bips       <= bips_nxt;
      buzzer     <= (estado_nxt == BEEP_ON);
      led_alerta <= (estado_nxt inside {BEEP_ON, BEEP_OFF, MUTE});
      mudo       <= (estado_nxt == MUTE);
    end
  end

endmodule

// File: tb/tb_buzzer_alerta_farol.sv
// Directed bench for buzzer_alerta_farol: table-driven short sequences plus
// hand-written runs for the long beeping patterns, reset and MAX_BEEPS=0.
module tb_buzzer_alerta_farol;

  typedef struct {
    logic  a;
    logic  s;
    logic  b;
    logic  l;
    logic  m;
    string nome;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alerta = 1'b0, silenciar = 1'b0;
  logic buzzer, led_alerta, mudo;
  logic alerta0 = 1'b0, silenciar0 = 1'b0;
  logic buzzer0, led0, mudo0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  buzzer_alerta_farol dut (
    .clk(clk), .rst(rst), .alerta(alerta), .silenciar(silenciar),
    .buzzer(buzzer), .led_alerta(led_alerta), .mudo(mudo)
  );

  buzzer_alerta_farol #(.MAX_BEEPS(0)) dut0 (
    .clk(clk), .rst(rst), .alerta(alerta0), .silenciar(silenciar0),
    .buzzer(buzzer0), .led_alerta(led0), .mudo(mudo0)
  );

  task automatic check(input string nome, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nome, act, exp);
    end
  endtask

  task automatic chk_outs(input string nome, input logic eb, input logic el, input logic em);
    check({nome, ".buzzer"}, buzzer, eb);
    check({nome, ".led"}, led_alerta, el);
    check({nome, ".mudo"}, mudo, em);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    alerta    = v.a;
    silenciar = v.s;
    step();
    chk_outs(v.nome, v.b, v.l, v.m);
  endtask

  // Expected outputs n edges after alerta was first sampled high from IDLE,
  // alerta held high, default timing (debounce 4, 8 on / 8 off).
  function automatic void modelo(input int n, input int max_b,
                                 output logic b, output logic l, output logic m);
    if (n < 5) begin
      b = 0; l = 0; m = 0;
    end else if ((max_b != 0) && (n >= 5 + 16 * max_b)) begin
      b = 0; l = 1; m = 1;
    end else begin
      b = (((n - 5) % 16) < 8); l = 1; m = 0;
    end
  endfunction

  // Hold alerta high for edges first..last, checking the main DUT each edge.
  task automatic run_high(input string nome, input int first, input int last);
    logic eb, el, em;
    alerta    = 1'b1;
    silenciar = 1'b0;
    for (int n = first; n <= last; n++) begin
      step();
      modelo(n, 5, eb, el, em);
      chk_outs($sformatf("%s@%0d", nome, n), eb, el, em);
    end
  endtask

  vec_t tab_deb[5];
  vec_t tab_mute[6];
  vec_t tab_simul[2];

  initial begin
    tab_deb[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "deb_rej1"};
    tab_deb[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "deb_rej2"};
    tab_deb[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "deb_rej3"};
    tab_deb[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "deb_rej_low"};
    tab_deb[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "deb_rej_idle"};

    tab_mute[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "mute_in_off"};
    tab_mute[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "mute_hold"};
    tab_mute[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mute_exit"};
    tab_mute[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "deb_again"};
    tab_mute[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "mute_in_deb"};
    tab_mute[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mute_deb_exit"};

    tab_simul[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "drop_and_mute"};
    tab_simul[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "drop_idle"};

    // Reset state
    #12;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset0.buzzer", buzzer0, 1'b0);
    rst = 1'b0;

    // Short glitch never beeps
    foreach (tab_deb[i]) apply(tab_deb[i]);

    // Warning clears during the 2nd beep, then a fresh debounce is needed
    run_high("clr_mid", 1, 23);
    alerta = 1'b0;
    step();
    chk_outs("clr_mid_drop", 1'b0, 1'b0, 1'b0);
    run_high("clr_rearm", 1, 5);
    alerta = 1'b0;
    step();
    chk_outs("clr_rearm_drop", 1'b0, 1'b0, 1'b0);

    // Nominal: five beeps then steady LED in MUTE
    run_high("nominal", 1, 100);
    alerta = 1'b0;
    step();
    chk_outs("nominal_exit", 1'b0, 1'b0, 1'b0);

    // Mute request during BEEP_OFF, and during DEBOUNCE
    run_high("mute_pre", 1, 13);
    foreach (tab_mute[i]) apply(tab_mute[i]);

    // alerta drop wins over a simultaneous mute request
    run_high("simul_pre", 1, 7);
    foreach (tab_simul[i]) apply(tab_simul[i]);

    // Asynchronous reset in the middle of BEEP_ON
    run_high("rst_pre", 1, 6);
    #2 rst = 1'b1;
    #1;
    chk_outs("rst_async", 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("rst_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run_high("rst_post", 1, 5);
    alerta = 1'b0;
    step();
    chk_outs("rst_post_drop", 1'b0, 1'b0, 1'b0);

    // MAX_BEEPS=0: beeps forever, never mutes
    alerta0 = 1'b1;
    for (int n = 1; n <= 500; n++) begin
      logic eb, el, em;
      step();
      modelo(n, 0, eb, el, em);
      check($sformatf("forever@%0d.buzzer", n), buzzer0, eb);
      check($sformatf("forever@%0d.led", n), led0, el);
      check($sformatf("forever@%0d.mudo", n), mudo0, em);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
